// File: rtl/led_scroll_ctrl.sv
// LED position controller: one lit LED (or a bar) stepped by debounced buttons.
// Optional build macro LED_SCROLL_BAR_EN selects a thermometer bar instead of one-hot.
module led_scroll_ctrl #(
    parameter int WIDTH         = 8,
    parameter int RESET_POS     = 0,
    parameter int WRAP          = 0,
    parameter int HOLD_CYCLES   = 0,
    parameter int REPEAT_CYCLES = 1,
    localparam int PW           = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dLef,
    input  logic             dRig,
    input  logic             dCen,
    output logic [WIDTH-1:0] LED,
    output logic [PW-1:0]    pos,
    output logic             at_left,
    output logic             at_right,
    output logic             step_pulse
);

    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
    localparam logic [PW-1:0] POS_RST = PW'(RESET_POS);
    localparam logic [CW-1:0] HOLD_LD = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] REP_LD  = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT,
        S_WAIT
    } state_e;

    function automatic logic [WIDTH-1:0] led_of(input logic [PW-1:0] p);
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) begin
`ifdef LED_SCROLL_BAR_EN
            v[i] = (i <= int'(p));
`else
            v[i] = (i == int'(p));
`endif
        end
        return v;
    endfunction

    localparam logic [WIDTH-1:0] LED_RST = led_of(POS_RST);

    state_e           state_q, state_d;
    logic [1:0]       dir_c, dir_q, dir_d;
    logic             dir_valid;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pos_q, pos_d, pos_step;
    logic [WIDTH-1:0] led_q, led_d;
    logic             pulse_q, pulse_d;
    logic             step_req;

    // {left, right} one-hot when exactly one button is down, else zero
    assign dir_c     = {dLef & ~dRig, dRig & ~dLef};
    assign dir_valid = dLef ^ dRig;

    // Candidate position for a step in the current direction (saturate or wrap)
    always_comb begin
        pos_step = pos_q;
        if (dir_c[1]) begin
            if (pos_q == POS_MAX) pos_step = (WRAP != 0) ? '0 : pos_q;
            else                  pos_step = pos_q + PW'(1);
        end else if (dir_c[0]) begin
            if (pos_q == '0) pos_step = (WRAP != 0) ? POS_MAX : pos_q;
            else             pos_step = pos_q - PW'(1);
        end
    end

    // Press / hold-delay / auto-repeat sequencing; re-centre overrides everything
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        step_req = 1'b0;
        if (dCen) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (dir_valid) begin
                        step_req = 1'b1;
                        dir_d    = dir_c;
                        cnt_d    = HOLD_LD;
                        state_d  = (HOLD_CYCLES == 0) ? S_WAIT : S_DELAY;
                    end
                end
                S_DELAY, S_REPEAT: begin
                    if (dir_c != dir_q) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == '0) begin
                        step_req = 1'b1;
                        cnt_d    = REP_LD;
                        state_d  = S_REPEAT;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_WAIT: begin
                    if (dir_c != dir_q) state_d = S_IDLE;
                end
            endcase
        end
    end

    // Next position, LED pattern and step pulse (only when pos really moves)
    always_comb begin
        pos_d   = pos_q;
        pulse_d = 1'b0;
        if (dCen) begin
            pos_d = POS_RST;
        end else if (step_req) begin
            pos_d   = pos_step;
            pulse_d = (pos_step != pos_q);
        end
        led_d = led_of(pos_d);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= POS_RST;
            led_q   <= LED_RST;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            led_q   <= led_d;
            pulse_q <= pulse_d;
        end
    end

    assign LED        = led_q;
    assign pos        = pos_q;
    assign at_left    = (pos_q == POS_MAX);
    assign at_right   = (pos_q == '0);
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_led_scroll_ctrl.sv
// Self-checking bench for led_scroll_ctrl: vector table plus directed corner cases.
// Three instances: saturating hold/repeat, wrapping, and single-step (no auto-repeat).
module tb_led_scroll_ctrl;

    logic clk = 1'b0;
    logic rst_n, dLef, dRig, dCen;

    logic [7:0] led0, led1, led2;
    logic [2:0] pos0, pos1, pos2;
    logic       al0, ar0, sp0, al1, ar1, sp1, al2, ar2, sp2;

    int nchk  = 0;
    int nfail = 0;
    int npulse;

    always #5 clk = ~clk;

    led_scroll_ctrl #(.WIDTH(8), .RESET_POS(0), .WRAP(0), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .dLef(dLef), .dRig(dRig), .dCen(dCen),
        .LED(led0), .pos(pos0), .at_left(al0), .at_right(ar0), .step_pulse(sp0));

    led_scroll_ctrl #(.WIDTH(8), .RESET_POS(0), .WRAP(1), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .dLef(dLef), .dRig(dRig), .dCen(dCen),
        .LED(led1), .pos(pos1), .at_left(al1), .at_right(ar1), .step_pulse(sp1));

    led_scroll_ctrl #(.WIDTH(8), .RESET_POS(0), .WRAP(0), .HOLD_CYCLES(0), .REPEAT_CYCLES(1)) u2 (
        .clk(clk), .rst_n(rst_n), .dLef(dLef), .dRig(dRig), .dCen(dCen),
        .LED(led2), .pos(pos2), .at_left(al2), .at_right(ar2), .step_pulse(sp2));

    typedef struct packed {
        logic       l;
        logic       r;
        logic       c;
        logic [2:0] pos;
        logic       pulse;
    } vec_t;

    vec_t vecs[34];

    function automatic vec_t mk(input logic l, r, c, input int p, input logic pl);
        vec_t v;
        v.l = l; v.r = r; v.c = c; v.pos = 3'(p); v.pulse = pl;
        return v;
    endfunction

    function automatic logic [7:0] exp_led(input int p);
        logic [8:0] one;
        one = 9'd1;
`ifdef LED_SCROLL_BAR_EN
        return 8'((one << (p + 1)) - 9'd1);
`else
        return 8'(one << p);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input logic l, r, c);
        @(negedge clk);
        dLef = l; dRig = r; dCen = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; dLef = 1'b0; dRig = 1'b0; dCen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // idle / single steps / saturation / both pressed
        vecs[0]  = mk(1, 0, 0, 1, 1);
        vecs[1]  = mk(0, 0, 0, 1, 0);
        vecs[2]  = mk(0, 1, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0);
        // left held 12 cycles: steps at 0,4,6,8,10
        vecs[8]  = mk(1, 0, 0, 1, 1);
        vecs[9]  = mk(1, 0, 0, 1, 0);
        vecs[10] = mk(1, 0, 0, 1, 0);
        vecs[11] = mk(1, 0, 0, 1, 0);
        vecs[12] = mk(1, 0, 0, 2, 1);
        vecs[13] = mk(1, 0, 0, 2, 0);
        vecs[14] = mk(1, 0, 0, 3, 1);
        vecs[15] = mk(1, 0, 0, 3, 0);
        vecs[16] = mk(1, 0, 0, 4, 1);
        vecs[17] = mk(1, 0, 0, 4, 0);
        vecs[18] = mk(1, 0, 0, 5, 1);
        vecs[19] = mk(1, 0, 0, 5, 0);
        vecs[20] = mk(0, 0, 0, 5, 0);
        // direction swap costs one idle cycle
        vecs[21] = mk(1, 0, 0, 6, 1);
        vecs[22] = mk(0, 1, 0, 6, 0);
        vecs[23] = mk(0, 1, 0, 5, 1);
        vecs[24] = mk(0, 0, 0, 5, 0);
        // hold into repeat, then re-centre
        vecs[25] = mk(1, 0, 0, 6, 1);
        vecs[26] = mk(1, 0, 0, 6, 0);
        vecs[27] = mk(1, 0, 0, 6, 0);
        vecs[28] = mk(1, 0, 0, 6, 0);
        vecs[29] = mk(1, 0, 0, 7, 1);
        vecs[30] = mk(1, 0, 0, 7, 0);
        vecs[31] = mk(1, 0, 1, 0, 0);
        vecs[32] = mk(1, 0, 0, 1, 1);
        vecs[33] = mk(0, 0, 0, 1, 0);

        rst_n = 1'b0; dLef = 1'b0; dRig = 1'b0; dCen = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_led", 32'(led0), 32'(exp_led(0)));
        check("reset_pos", 32'(pos0), 32'd0);
        check("reset_at_right", 32'(ar0), 32'd1);
        check("reset_at_left", 32'(al0), 32'd0);
        check("reset_pulse", 32'(sp0), 32'd0);

        for (int i = 0; i < 34; i++) begin
            cyc(vecs[i].l, vecs[i].r, vecs[i].c);
            check($sformatf("vec%0d_pos", i), 32'(pos0), 32'(vecs[i].pos));
            check($sformatf("vec%0d_pulse", i), 32'(sp0), 32'(vecs[i].pulse));
            check($sformatf("vec%0d_led", i), 32'(led0), 32'(exp_led(int'(vecs[i].pos))));
            check($sformatf("vec%0d_at_left", i), 32'(al0), 32'(vecs[i].pos == 3'd7));
            check($sformatf("vec%0d_at_right", i), 32'(ar0), 32'(vecs[i].pos == 3'd0));
        end

        // wrap versus saturate at the left end
        do_reset();
        repeat (7) begin
            cyc(1, 0, 0);
            cyc(0, 0, 0);
        end
        check("sat_pos7", 32'(pos0), 32'd7);
        check("wrap_pos7", 32'(pos1), 32'd7);
        check("single_pos7", 32'(pos2), 32'd7);
        cyc(1, 0, 0);
        check("wrap_led", 32'(led1), 32'(exp_led(0)));
        check("wrap_pos", 32'(pos1), 32'd0);
        check("wrap_pulse", 32'(sp1), 32'd1);
        check("wrap_at_right", 32'(ar1), 32'd1);
        check("sat_led", 32'(led0), 32'(exp_led(7)));
        check("sat_pulse", 32'(sp0), 32'd0);
        cyc(0, 0, 0);

        // wrap at the right end
        cyc(0, 1, 0);
        check("wrap_right_pos", 32'(pos1), 32'd7);
        check("wrap_right_pulse", 32'(sp1), 32'd1);
        cyc(0, 0, 0);

        // three single presses from reset
        do_reset();
        repeat (3) begin
            cyc(1, 0, 0);
            cyc(0, 0, 0);
        end
        check("three_press_led", 32'(led0), 32'(exp_led(3)));

        // no auto-repeat: long hold gives one step
        do_reset();
        npulse = 0;
        repeat (10) begin
            cyc(1, 0, 0);
            npulse += int'(sp2);
        end
        check("hold0_pulses", 32'(npulse), 32'd1);
        check("hold0_pos", 32'(pos2), 32'd1);
        check("hold_rep_pos", 32'(pos0), 32'd4);
        cyc(0, 0, 0);

        // asynchronous reset in the middle of a hold
        do_reset();
        repeat (3) cyc(1, 0, 0);
        check("midhold_pos", 32'(pos0), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_led", 32'(led0), 32'(exp_led(0)));
        check("async_pos", 32'(pos0), 32'd0);
        @(negedge clk);
        dLef = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0);
        check("after_rst_pos", 32'(pos0), 32'd1);
        check("after_rst_pulse", 32'(sp0), 32'd1);
        cyc(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
